// File: rtl/div_seq.sv
// Sequencer between the pipeline and an iterative divider: latches operands,
// starts the divider, handles divide-by-zero, flush, watchdog and the HI/LO write.
module div_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_req,
    input  logic        div_sign,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flushM,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        stall_div,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata,
    output logic        div_timeout
);
    localparam logic [5:0] TMO_LIMIT = 6'd40;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ZERO} state_e;

    state_e      state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        sign_q, sign_d;
    logic [63:0] hilo_q, hilo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic [5:0]  cnt_inc;
    logic        start_c, annul_c, we_c, stall_c, tmo_now;

    assign cnt_inc = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sign_d  = sign_q;
        hilo_d  = hilo_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        start_c = 1'b0;
        annul_c = 1'b0;
        we_c    = 1'b0;
        stall_c = 1'b0;
        tmo_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_req && !flushM) begin
                    stall_c = 1'b1;
                    opa_d   = opa;
                    opb_d   = opb;
                    sign_d  = div_sign;
                    cnt_d   = 6'd0;
                    state_d = (opb == 32'd0) ? ZERO : BUSY;
                end
            end
            BUSY: begin
                start_c = 1'b1;
                stall_c = 1'b1;
                cnt_d   = cnt_inc;
                // Flush beats a same-cycle ready: the instruction is being killed.
                if (flushM) begin
                    annul_c = 1'b1;
                    state_d = IDLE;
                end else if (div_ready) begin
                    hilo_d  = div_result;
                    state_d = DONE;
                end else if (cnt_inc == TMO_LIMIT) begin
                    annul_c = 1'b1;
                    tmo_now = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            ZERO: begin
                stall_c = 1'b1;
                if (flushM) begin
                    annul_c = 1'b1;
                    state_d = IDLE;
                end else begin
                    hilo_d  = {opa_q, 32'hFFFF_FFFF};
                    state_d = DONE;
                end
            end
            DONE: begin
                // Same instruction retiring; a held div_req here is not a new request.
                we_c    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sign_q  <= 1'b0;
            hilo_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sign_q  <= sign_d;
            hilo_q  <= hilo_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Combinational controls are forced low while reset is held.
    assign div_start   = resetn & start_c;
    assign div_annul   = resetn & annul_c;
    assign hilo_we     = resetn & we_c;
    assign stall_div   = resetn & stall_c;
    assign div_timeout = tmo_q | (resetn & tmo_now);
    assign div_opa     = opa_q;
    assign div_opb     = opb_q;
    assign div_signed  = sign_q;
    assign hilo_wdata  = hilo_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a cycle-driven divider stand-in raises div_ready
// at a chosen BUSY cycle and results are compared to hand-computed values.
module tb_div_seq;
    logic        clk = 1'b0;
    logic        resetn, div_req, div_sign, flushM, div_ready;
    logic [31:0] opa, opb;
    logic [63:0] div_result;
    logic        div_start, div_signed, div_annul, stall_div, hilo_we, div_timeout;
    logic [31:0] div_opa, div_opb;
    logic [63:0] hilo_wdata;

    int nchk = 0;
    int errs = 0;

    int          r_stall, r_start, r_we, r_annul, r_we_c, r_annul_c, r_bad;
    logic        r_stall_we, r_tmo_annul;
    logic [63:0] r_wd;

    always #5 clk = ~clk;

    div_seq dut (
        .clk(clk), .resetn(resetn), .div_req(div_req), .div_sign(div_sign),
        .opa(opa), .opb(opb), .flushM(flushM), .div_ready(div_ready),
        .div_result(div_result), .div_start(div_start), .div_signed(div_signed),
        .div_annul(div_annul), .div_opa(div_opa), .div_opb(div_opb),
        .stall_div(stall_div), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
        .div_timeout(div_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        div_req    = 1'b0;
        div_sign   = 1'b0;
        flushM     = 1'b0;
        div_ready  = 1'b0;
        opa        = 32'h0;
        opb        = 32'h0;
        div_result = 64'h0;
    endtask

    // One instruction: accept at c==0, ready/flush on the given BUSY cycle (0 = never).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] res, input int rdy_at, input int fl_at,
                          input bit keep_req);
        int nb;
        bit done;
        nb = 0; done = 0;
        r_stall = 0; r_start = 0; r_we = 0; r_annul = 0; r_bad = 0;
        r_we_c = -1; r_annul_c = -1; r_wd = '0; r_stall_we = 1'bx; r_tmo_annul = 1'bx;
        for (int c = 0; c < 60 && !done; c++) begin
            div_req    = (c == 0) || keep_req;
            div_sign   = s;
            opa        = (c == 0) ? a : ~a;
            opb        = (c == 0) ? b : b + 32'd3;
            div_ready  = 1'b0;
            flushM     = 1'b0;
            div_result = 64'hBAD0_BAD0_BAD0_BAD0;
            #1;
            if (div_start) nb++;
            if (div_start && nb == rdy_at) begin
                div_ready  = 1'b1;
                div_result = res;
            end
            if (div_start && nb == fl_at) flushM = 1'b1;
            #1;
            if (stall_div) r_stall++;
            if (div_start) begin
                r_start++;
                if (div_opa !== a || div_opb !== b || div_signed !== s) r_bad++;
            end
            if (hilo_we) begin
                r_we++; r_we_c = c; r_wd = hilo_wdata; r_stall_we = stall_div; done = 1;
            end
            if (div_annul) begin
                r_annul++; r_annul_c = c; r_tmo_annul = div_timeout; done = 1;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        step();
        // Reset overrides live inputs
        div_req = 1'b1; div_ready = 1'b1; opb = 32'd5; opa = 32'd9;
        step();
        #1;
        chk("reset_ctrl", {stall_div, div_start, hilo_we, div_annul}, 4'b0000);
        step();
        idle_inputs();
        resetn = 1'b1;
        #1;
        chk("reset_opa", div_opa, 0);
        chk("reset_opb", div_opb, 0);
        chk("reset_sgn", div_signed, 0);
        chk("reset_hilo", hilo_wdata, 0);
        chk("reset_tmo", div_timeout, 0);
        step();

        // Request killed by flush in IDLE: no stall, nothing latched
        div_req = 1'b1; flushM = 1'b1; opa = 32'hAAAA_AAAA; opb = 32'h3;
        #1;
        chk("idle_flush_stall", stall_div, 0);
        step();
        idle_inputs();
        #1;
        chk("idle_flush_start", div_start, 0);
        chk("idle_flush_opa", div_opa, 0);

        // Signed -7 / 2: ready on 33rd BUSY cycle
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 0, 0);
        chk("sdiv_stall", r_stall, 34);
        chk("sdiv_start", r_start, 33);
        chk("sdiv_we_cyc", r_we_c, 34);
        chk("sdiv_we_n", r_we, 1);
        chk("sdiv_wdata", r_wd, 64'hFFFFFFFF_FFFFFFFD);
        chk("sdiv_stall_we", r_stall_we, 0);
        chk("sdiv_annul", r_annul, 0);
        chk("sdiv_opstable", r_bad, 0);

        // Divide by zero
        run_op(32'h1234_5678, 32'd0, 1'b0, 64'h0, 0, 0, 0);
        chk("dz_start", r_start, 0);
        chk("dz_we_cyc", r_we_c, 2);
        chk("dz_wdata", r_wd, 64'h12345678_FFFFFFFF);
        chk("dz_stall", r_stall, 2);

        // Flush on BUSY cycle 10, then stray ready pulses
        run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 0, 10, 0);
        chk("fl_annul_cyc", r_annul_c, 10);
        chk("fl_we", r_we, 0);
        chk("fl_start", r_start, 10);
        #1;
        chk("fl_idle", {stall_div, div_start}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            div_ready = 1'b1; div_result = 64'hCAFE_0000_0000_0000 + 64'(i);
            #1;
            chk("stray_ready_we", hilo_we, 0);
            step();
        end
        idle_inputs();
        chk("fl_hilo_kept", hilo_wdata, 64'h12345678_FFFFFFFF);

        // Flush and ready in the same BUSY cycle
        run_op(32'd50, 32'd5, 1'b0, 64'h00000000_0000000A, 5, 5, 0);
        chk("flrdy_annul_cyc", r_annul_c, 5);
        chk("flrdy_we", r_we, 0);
        chk("flrdy_hilo_kept", hilo_wdata, 64'h12345678_FFFFFFFF);

        // Back-to-back DIVU with div_req held through DONE
        run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 4, 0, 1);
        chk("b2b1_we_cyc", r_we_c, 5);
        chk("b2b1_wdata", r_wd, 64'h00000002_0000000E);
        chk("b2b1_stall", r_stall, 5);
        chk("b2b1_opstable", r_bad, 0);
        run_op(32'd9, 32'd2, 1'b0, 64'h00000001_00000004, 3, 0, 0);
        chk("b2b2_stall", r_stall, 4);
        chk("b2b2_start", r_start, 3);
        chk("b2b2_we_cyc", r_we_c, 4);
        chk("b2b2_wdata", r_wd, 64'h00000001_00000004);
        chk("b2b2_opstable", r_bad, 0);

        // Watchdog: ready never comes
        run_op(32'd1000, 32'd3, 1'b1, 64'h0, 0, 0, 0);
        chk("wd_annul_cyc", r_annul_c, 40);
        chk("wd_start", r_start, 40);
        chk("wd_we", r_we, 0);
        chk("wd_tmo_at_annul", r_tmo_annul, 1);
        chk("wd_tmo_after", div_timeout, 1);
        chk("wd_hilo_kept", hilo_wdata, 64'h00000001_00000004);
        run_op(32'd10, 32'd3, 1'b0, 64'h00000001_00000003, 2, 0, 0);
        chk("post_wd_wdata", r_wd, 64'h00000001_00000003);
        chk("wd_tmo_sticky", div_timeout, 1);
        resetn = 1'b0;
        step();
        chk("wd_tmo_reset", div_timeout, 0);
        chk("reset2_hilo", hilo_wdata, 0);
        resetn = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, errs);
        $finish;
    end
endmodule
